// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the weight/activation memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 3;

  localparam int unsigned REQ_LOAD = 0;
  localparam int unsigned REQ_RUN  = 1;
  localparam int unsigned REQ_HOST = 2;

  typedef enum logic {
    ARB_FREE,
    ARB_OWNED
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Per-requester saturating wait counter; flags the requester as aged once
// it has waited AGE_LIMIT cycles without a grant.
module mem_arb_age_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic gnt,
  output logic aged
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!req || gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign aged = (32'(r_cnt) >= AGE_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: load > run > host fixed priority with lock
// bursts; optional starvation aging under MEM_ARB_AGING_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned AGE_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      addr_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  if (AGE_LIMIT == 0 || AGE_LIMIT > 255) begin : g_bad_age_limit
    $error("AGE_LIMIT must fit the 8-bit wait counter (1..255)");
  end

  arb_state_t          r_state, w_state_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [NUM_REQ-1:0]  w_aged;
  logic [NUM_REQ-1:0]  w_rvalid;
  logic [1:0]          w_sel;
  logic                w_found;
  logic                w_acc;
  logic                w_in_range;
  logic                w_we_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [DATA_W-1:0]   w_wdata_sel;

  logic                r_mem_en;
  logic                r_mem_we;
  logic                r_addr_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  tag_t                r_tag1, r_tag2;

`ifdef MEM_ARB_AGING_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
    mem_arb_age_ctr #(.AGE_LIMIT(AGE_LIMIT)) u_age (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (req[gi]),
      .gnt    (w_gnt[gi]),
      .aged   (w_aged[gi])
    );
  end
`else
  assign w_aged = '0;
`endif

  // Aged requesters are scanned first, so the lowest aged index wins in FREE.
  always_comb begin
    w_gnt   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    if (r_state == ARB_OWNED) begin
      w_sel          = r_owner;
      w_gnt[r_owner] = req[r_owner];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req[i] && w_aged[i]) begin
          w_found = 1'b1;
          w_sel   = 2'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req[i]) begin
          w_found = 1'b1;
          w_sel   = 2'(i);
        end
      end
      if (w_found) w_gnt[w_sel] = 1'b1;
    end
    if (!reset_n) w_gnt = '0;
  end

  assign w_acc       = |(req & w_gnt);
  assign w_we_sel    = we[w_sel];
  assign w_addr_sel  = addr[w_sel*ADDR_W +: ADDR_W];
  assign w_wdata_sel = wdata[w_sel*DATA_W +: DATA_W];
  assign w_in_range  = (32'(w_addr_sel) < MEM_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ARB_FREE: begin
        if (w_acc && lock[w_sel]) begin
          w_state_nxt = ARB_OWNED;
          w_owner_nxt = w_sel;
        end
      end
      ARB_OWNED: begin
        if (!req[r_owner] || !lock[r_owner]) w_state_nxt = ARB_FREE;
      end
      default: w_state_nxt = ARB_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_FREE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_addr_err  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
    end else begin
      r_mem_en     <= w_acc & w_in_range;
      r_mem_we     <= w_acc & w_in_range & w_we_sel;
      r_addr_err   <= w_acc & ~w_in_range;
      if (w_acc) begin
        r_mem_addr  <= w_addr_sel;
        r_mem_wdata <= w_wdata_sel;
      end
      r_tag1.valid <= w_acc & w_in_range & ~w_we_sel;
      r_tag1.idx   <= w_sel;
      r_tag2       <= r_tag1;
    end
  end

  always_comb begin
    w_rvalid = '0;
    if (r_tag2.valid) w_rvalid[r_tag2.idx] = 1'b1;
  end

  assign gnt       = w_gnt;
  assign rvalid    = w_rvalid;
  assign rdata     = mem_rdata;
  assign addr_err  = r_addr_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised plus directed bench for mem_arbiter against a transaction-level
// reference model; builds with or without MEM_ARB_AGING_EN.
module tb_mem_arbiter;

  localparam int NR    = 3;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1000;
  localparam int AGE   = 16;
`ifdef MEM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req, we, lock;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic             addr_err, mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;

  mem_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MEM_DEPTH(DEPTH),
    .AGE_LIMIT(AGE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .we       (we),
    .lock     (lock),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .addr_err (addr_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    return (a == 5) ? 16'hBEEF : 16'((a * 40503) ^ 16'h1234);
  endfunction

  // Memory macro: 1-cycle read latency, contents default to init_val.
  logic [15:0] mem_arr [1024];
  bit          mem_wr  [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr] <= mem_wdata;
        mem_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= mem_wr[mem_addr] ? mem_arr[mem_addr] : init_val(int'(mem_addr));
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] gold    [1024];
  bit          gold_wr [1024];
  int          owner = -1;
  int          waitc [NR];
  logic [NR-1:0] m_gnt = '0;
  logic [NR-1:0] last_gnt;
  bit          e_en, e_we, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  bit          rv1_v, rv2_v;
  int          rv1_i, rv2_i;
  logic [DW-1:0] rv1_d, rv2_d;

  function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] r);
    if (owner >= 0) return r[owner] ? NR'(1 << owner) : '0;
    if (AGING)
      for (int i = 0; i < NR; i++)
        if (r[i] && waitc[i] >= AGE) return NR'(1 << i);
    for (int i = 0; i < NR; i++)
      if (r[i]) return NR'(1 << i);
    return '0;
  endfunction

  task automatic model_clear();
    owner = -1; m_gnt = '0;
    e_en = 0; e_we = 0; e_err = 0;
    rv1_v = 0; rv2_v = 0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"},    64'(gnt), 64'(0));
    check_eq({tag, "_rvalid"}, 64'(rvalid), 64'(0));
    check_eq({tag, "_err"},    64'(addr_err), 64'(0));
    check_eq({tag, "_en"},     64'(mem_en), 64'(0));
    check_eq({tag, "_we"},     64'(mem_we), 64'(0));
    check_eq({tag, "_addr"},   64'(mem_addr), 64'(0));
    check_eq({tag, "_wdata"},  64'(mem_wdata), 64'(0));
  endtask

  // One cycle: called just after a rising edge, returns just after the next.
  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] w, input logic [NR-1:0] l,
                      input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    logic [NR-1:0] g;
    int sel;
    int ai;
    req = r; we = w; lock = l; addr = a; wdata = d;
    #1;
    g = model_grant(r);
    last_gnt = gnt;
    check_eq("gnt", 64'(gnt), 64'(g));
    check_eq("mem_en", 64'(mem_en), 64'(e_en));
    check_eq("mem_we", 64'(mem_we), 64'(e_we));
    check_eq("addr_err", 64'(addr_err), 64'(e_err));
    if (e_en) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
      check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    end
    check_eq("rvalid", 64'(rvalid), rv2_v ? 64'(1 << rv2_i) : 64'(0));
    if (rv2_v) check_eq("rdata", 64'(rdata), 64'(rv2_d));

    rv2_v = rv1_v; rv2_i = rv1_i; rv2_d = rv1_d;
    rv1_v = 0; e_en = 0; e_we = 0; e_err = 0;
    m_gnt = g;
    sel = -1;
    for (int i = 0; i < NR; i++) if (g[i]) sel = i;
    if (sel >= 0) begin
      ai = int'(a[sel*AW +: AW]);
      if (ai < DEPTH) begin
        e_en = 1; e_we = w[sel]; e_addr = AW'(ai); e_wd = d[sel*DW +: DW];
        if (w[sel]) begin
          gold[ai] = d[sel*DW +: DW]; gold_wr[ai] = 1'b1;
        end else begin
          rv1_v = 1; rv1_i = sel;
          rv1_d = gold_wr[ai] ? gold[ai] : init_val(ai);
        end
      end else begin
        e_err = 1;
      end
    end
    if (owner < 0) begin
      if (sel >= 0 && l[sel]) owner = sel;
    end else if (!r[owner] || !l[owner]) begin
      owner = -1;
    end
    for (int i = 0; i < NR; i++)
      waitc[i] = (r[i] && !g[i]) ? ((waitc[i] < 255) ? waitc[i] + 1 : 255) : 0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, '0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; requests are held high to show
  // that grants are suppressed, then dropped before release.
  task automatic reset_mid();
    #2;
    reset_n = 1'b0;
    req = '1;
    #1;
    check_all_zero("rst_mid");
    model_clear();
    repeat (2) @(posedge clk);
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [NR*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  initial begin
    logic [NR-1:0]    r, w, l;
    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;
    int host_first;

    reset_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 1024; i++) gold_wr[i] = 1'b0;
    model_clear();
    #3;
    check_all_zero("por");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Single host read of preloaded address 5
    step(3'b100, 3'b000, 3'b000, pa(0, 0, 5), '0);
    idle(3);

    // Three-way contention, each held until granted
    step(3'b111, 3'b000, 3'b000, pa(10, 11, 12), '0);
    step(3'b110, 3'b000, 3'b000, pa(10, 11, 12), '0);
    step(3'b100, 3'b000, 3'b000, pa(10, 11, 12), '0);
    idle(3);

    // Run locks a four-read burst while load waits
    step(3'b010, 3'b000, 3'b010, pa(0, 0, 0), '0);
    step(3'b011, 3'b000, 3'b010, pa(20, 1, 0), '0);
    step(3'b011, 3'b000, 3'b010, pa(20, 2, 0), '0);
    step(3'b011, 3'b000, 3'b000, pa(20, 3, 0), '0);
    step(3'b001, 3'b000, 3'b000, pa(20, 0, 0), '0);
    idle(3);

    // Boundary addresses: last valid and out of range
    step(3'b100, 3'b100, 3'b000, pa(0, 0, 999), {16'h1357, 32'h0});
    step(3'b100, 3'b100, 3'b000, pa(0, 0, 1023), {16'hDEAD, 32'h0});
    step(3'b100, 3'b000, 3'b000, pa(0, 0, 1000), '0);
    step(3'b100, 3'b000, 3'b000, pa(0, 0, 999), '0);
    idle(3);

    // Reset while a host read is in flight
    step(3'b100, 3'b000, 3'b000, pa(0, 0, 5), '0);
    check_eq("pre_rst_en", 64'(mem_en), 64'(1));
    reset_mid();
    idle(3);

    // Continuous load traffic against a waiting host
    host_first = -1;
    for (int c = 0; c < 100; c++) begin
      step(3'b101, 3'b000, 3'b000, pa($urandom_range(0, 63), 0, 7), '0);
      if (last_gnt[2] && host_first < 0) host_first = c;
    end
    check_eq("host_first_gnt", 64'(host_first), AGING ? 64'(16) : 64'(-1));
    idle(3);

    // Randomised traffic; requests held until granted, occasionally dropped
    r = '0; w = '0; l = '0; a = '0; d = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!r[i] || m_gnt[i] || $urandom_range(0, 15) == 0) begin
          r[i] = 1'($urandom_range(0, 1));
          w[i] = 1'($urandom_range(0, 1));
          l[i] = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 9))
            0:       a[i*AW +: AW] = 10'($urandom_range(1000, 1023));
            1:       a[i*AW +: AW] = 10'd999;
            default: a[i*AW +: AW] = 10'($urandom_range(0, 31));
          endcase
          d[i*DW +: DW] = 16'($urandom);
        end
      end
      if (c == 400) begin
        reset_mid();
        r = '0;
      end
      step(r, w, l, a, d);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port 1024×16 on-chip weight/activation memory among three requesters:
- the SDRAM load path (writes during load);
- the run-phase compute engine (reads);
- the host debug port (reads and writes).

The block accepts one access per cycle with a combinational grant, registers the command to the memory and returns tagged read valids after the memory's 1-cycle latency. It sits between control_unit/datapath masters and the memory macro, replacing direct wiring of mem_wr_en/mem_address.

## Interface
- NUM_REQ, 3: requester count; index 0 = load, 1 = run, 2 = host.
- ADDR_W, 10: memory address width.
- DATA_W, 16: memory data width.
- MEM_DEPTH, 1024: valid address range is 0..MEM_DEPTH-1.
- AGE_LIMIT, 16: wait cycles before a requester is promoted (aging build only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  access request per requester; held until granted.
- we  in  NUM_REQ  1 = write, 0 = read.
- lock  in  NUM_REQ  keep ownership after this access (burst).
- addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot combinational grant; access accepted when req[i]&gnt[i].
- rvalid  out  NUM_REQ  one-hot; read data for requester i valid on rdata.
- rdata  out  DATA_W  shared read data (mem_rdata pass-through).
- addr_err  out  1  one-cycle pulse: a granted access had addr ≥ MEM_DEPTH.
- mem_en, mem_we  out  1  registered memory command.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.

## Operation
- **States:** ARB_FREE, ARB_OWNED. Holds owner index (2 bits).
- **ARB_FREE:**
  - gnt goes to the highest-priority asserted req. Fixed priority is load > run > host.
  - If the granted request has lock=1, next state is ARB_OWNED with owner = that index.
- **ARB_OWNED:**
  - gnt[owner] = req[owner]; all other grants are 0, regardless of priority.
  - Exit to ARB_FREE on the first cycle the owner's access is accepted with lock=0, or when req[owner]=0. In the req=0 case, re-arbitration happens the next cycle.
- **No request:** gnt=0, mem_en=0 next cycle.
- **Command issue:** an accepted access registers mem_en=1, mem_we=we[i], mem_addr, mem_wdata into the next cycle.
- **Out-of-range address:**
  - If an accepted access has addr ≥ MEM_DEPTH, mem_en stays 0 and addr_err pulses next cycle.
  - A read to such an address produces no rvalid. gnt is still given, so the requester never hangs.
- **Read tag pipeline:** a 2-stage shift of {valid, index}. rvalid[index] is asserted 2 cycles after acceptance, coinciding with mem_rdata.
- **Reset values:** all outputs 0; state ARB_FREE; tag pipeline cleared. Reset mid-burst drops ownership, and in-flight reads never produce rvalid.

## Timing
- Cycle N: req[i]&gnt[i] → access accepted.
- Cycle N+1: mem_en/mem_we/mem_addr/mem_wdata valid; addr_err if applicable.
- Cycle N+2: rvalid[i]=1, rdata=mem_rdata (reads only).
- **Throughput:** one access per cycle. Back-to-back accesses from different requesters give back-to-back rvalids in acceptance order.
- **Simultaneous events:** a read and a write to the same address in consecutive cycles are issued in acceptance order; the memory returns old-data or new-data per the macro and no forwarding is done.
- **Grant path:** gnt depends combinationally on req, lock state and age flags only, never on addr/wdata.

## Configuration
- Macro: MEM_ARB_AGING_EN.
- **Defined:**
  - One 8-bit saturating wait counter per requester. It increments each cycle req[i]=1 and gnt[i]=0, and clears on grant or when req drops.
  - When a counter reaches AGE_LIMIT, that requester is aged. The lowest aged index beats fixed priority in ARB_FREE.
  - Ownership in ARB_OWNED is never pre-empted.
- **Undefined:** pure fixed priority; host may starve indefinitely under continuous load traffic.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum (ARB_FREE, ARB_OWNED);
  - requester index constants REQ_LOAD=0, REQ_RUN=1, REQ_HOST=2;
  - NUM_REQ default;
  - tag struct {logic valid; logic [1:0] idx}.
- Sub-module mem_arb_age_ctr: one wait counter plus aged flag per instance. It is instantiated NUM_REQ times under MEM_ARB_AGING_EN only.

## Test plan
- **Single read:** host req, we=0, addr=5, with mem preloaded 0xBEEF → gnt[2] same cycle; mem_en/mem_addr=5 at N+1; rvalid[2]=1 and rdata=0xBEEF at N+2.
- **Priority:** load, run and host req together, no lock → grants in order 0,1,2 over three cycles; rvalid order matches for reads.
- **Lock burst:** run locks 4 reads at addr 0..3 while load requests → load gnt=0 for 4 cycles; load granted the cycle after run's lock=0 access.
- **Out-of-range:** host write addr=1023 with MEM_DEPTH=1000 → gnt[2]=1, mem_en=0, addr_err pulse at N+1.
- **Aging:**
  - With MEM_ARB_AGING_EN and AGE_LIMIT=16, load requests continuously and host waits → host granted on its 17th cycle of waiting.
  - Without the macro → host never granted during 100 cycles of continuous load requests.
- **Reset mid-read:** reset_n low at N+1 of a read → rvalid stays 0; state ARB_FREE; all outputs 0 until reset release.
